// File: rtl/pipe_stage_fifo.sv
// Elastic inter-stage pipeline buffer: DEPTH_P-entry circular queue with
// valid/ready handshakes on both sides and a synchronous flush.
module pipe_stage_fifo #(
  parameter int WIDTH_P        = 32,
  parameter int DEPTH_P        = 2,
  parameter bit ZERO_INVALID_P = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_v_i,
  input  logic                         v_i,
  input  logic [WIDTH_P-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [WIDTH_P-1:0]           data_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CNT_W = $clog2(DEPTH_P + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  ptr_t               rd_ptr;
  ptr_t               wr_ptr;
  cnt_t               count;
  logic               enq;
  logic               deq;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(DEPTH_P - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // ready_o is a function of occupancy only, so a full queue refuses input
  // even when the head leaves in the same cycle.
  assign ready_o = (count != cnt_t'(DEPTH_P));
  assign v_o     = (count != '0) && !flush_v_i;
  assign enq     = v_i && ready_o && !flush_v_i;
  assign deq     = v_o && ready_i;
  assign count_o = count;
  assign data_o  = (v_o || !ZERO_INVALID_P) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_v_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_next(wr_ptr);
      if (deq) rd_ptr <= ptr_next(rd_ptr);
      if (enq && !deq)      count <= count + cnt_t'(1);
      else if (deq && !enq) count <= count - cnt_t'(1);
    end
  end

  // NOTE: payload storage has no reset; validity is tracked by count alone,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= cnt_t'(DEPTH_P));
  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(deq && (count == '0)));
  a_data_known: assert property (@(posedge clk_i) disable iff (rst_i)
    v_i |-> !$isunknown(data_i));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench: a queue-based reference model for a depth-3 instance plus
// directed backpressure checks on a depth-2 instance.
module tb_pipe_stage_fifo;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // depth-3 instance (scoreboarded)
  logic         fl3, v3, rdy3;
  logic [W-1:0] d3;
  logic         rdy_o3, vo3;
  logic [W-1:0] do3;
  logic [1:0]   cnt3;

  // depth-2 instance (directed backpressure)
  logic         fl2, v2, rdy2;
  logic [W-1:0] d2;
  logic         rdy_o2, vo2;
  logic [W-1:0] do2;
  logic [1:0]   cnt2;

  pipe_stage_fifo #(.WIDTH_P(W), .DEPTH_P(3), .ZERO_INVALID_P(1'b1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_v_i(fl3), .v_i(v3), .data_i(d3),
    .ready_o(rdy_o3), .v_o(vo3), .data_o(do3), .ready_i(rdy3), .count_o(cnt3)
  );

  pipe_stage_fifo #(.WIDTH_P(W), .DEPTH_P(2), .ZERO_INVALID_P(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_v_i(fl2), .v_i(v2), .data_i(d2),
    .ready_o(rdy_o2), .v_o(vo2), .data_o(do2), .ready_i(rdy2), .count_o(cnt2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model for the depth-3 queue: occupancy and queued payloads.
  int           model_cnt = 0;
  logic [W-1:0] exp_q[$];
  int           n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus into the depth-3 instance; model advances on the edge.
  task automatic step3(input bit v, input logic [W-1:0] d, input bit rdy, input bit fl);
    bit enq, deq;
    v3 = v; d3 = d; rdy3 = rdy; fl3 = fl;
    @(posedge clk);
    if (fl) begin
      model_cnt = 0;
      exp_q.delete();
    end else begin
      deq = (model_cnt > 0) && rdy;
      enq = v && (model_cnt < 3);
      if (enq) exp_q.push_back(d);
      model_cnt = model_cnt + int'(enq) - int'(deq);
    end
    #1;
  endtask

  task automatic step2(input bit v, input logic [W-1:0] d, input bit rdy);
    v2 = v; d2 = d; rdy2 = rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle sampling of the depth-3 outputs against the model.
  always @(negedge clk) begin
    check("v_o", {31'b0, vo3}, {31'b0, (model_cnt != 0) && !fl3});
    check("ready_o", {31'b0, rdy_o3}, {31'b0, model_cnt != 3});
    check("count_o", {30'b0, cnt3}, model_cnt);
    if (vo3) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got v_o=1 data=%0h expected empty queue", do3);
      end else if (rdy3) begin
        check("data_o", {16'b0, do3}, {16'b0, exp_q.pop_front()});
        n_out++;
      end else begin
        check("data_hold", {16'b0, do3}, {16'b0, exp_q[0]});
      end
    end else begin
      check("bubble_zero", {16'b0, do3}, 32'h0);
    end
  end

  initial begin
    bit           pend;
    bit           fl, rdy;
    logic [W-1:0] pd;
    int           base;

    // 1: reset held with v_i=1; monitor checks outputs during and after.
    rst = 1'b1;
    fl3 = 1'b0; v3 = 1'b1; d3 = 16'h0055; rdy3 = 1'b1;
    fl2 = 1'b0; v2 = 1'b1; d2 = 16'h0066; rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v2", {31'b0, vo2}, 32'h0);
    check("rst_cnt2", {30'b0, cnt2}, 32'h0);
    check("rst_ready2", {31'b0, rdy_o2}, 32'h1);
    rst = 1'b0;
    v3 = 1'b0; v2 = 1'b0;
    step3(0, '0, 1, 0);

    // 2: depth-2 fill, refuse while full, then drain in order.
    step2(1, 16'h00A1, 0);
    check("bp_cnt1", {30'b0, cnt2}, 32'h1);
    check("bp_data1", {16'b0, do2}, 32'h00A1);
    step2(1, 16'h00A2, 0);
    check("bp_cnt2", {30'b0, cnt2}, 32'h2);
    check("bp_full", {31'b0, rdy_o2}, 32'h0);
    step2(1, 16'h00A3, 0);
    check("bp_held_cnt", {30'b0, cnt2}, 32'h2);
    check("bp_held_head", {16'b0, do2}, 32'h00A1);
    rdy2 = 1'b1;
    #2;
    check("bp_full_rdy", {31'b0, rdy_o2}, 32'h0);
    step2(1, 16'h00A3, 1);
    check("bp_cnt_after_deq", {30'b0, cnt2}, 32'h1);
    check("bp_data2", {16'b0, do2}, 32'h00A2);
    step2(1, 16'h00A3, 1);
    check("bp_cnt_swap", {30'b0, cnt2}, 32'h1);
    check("bp_data3", {16'b0, do2}, 32'h00A3);
    step2(0, '0, 1);
    check("bp_empty_v", {31'b0, vo2}, 32'h0);
    check("bp_empty_data", {16'b0, do2}, 32'h0);

    // 3: streaming 0..99 through the depth-3 queue with ready_i high.
    base = n_out;
    for (int i = 0; i < 100; i++) step3(1, W'(i), 1, 0);
    repeat (2) step3(0, '0, 1, 0);
    check("stream_count", n_out - base, 100);

    // 4: flush at count=2 with an incoming entry in the same cycle.
    step3(1, 16'h0B01, 0, 0);
    step3(1, 16'h0B02, 0, 0);
    step3(1, 16'h0BEE, 1, 1);
    step3(0, '0, 1, 0);
    step3(0, '0, 1, 0);

    // 5: simultaneous enqueue/dequeue at count=1.
    step3(1, 16'h0C00, 0, 0);
    for (int i = 1; i <= 10; i++) step3(1, W'(16'h0C00 + i), 1, 0);
    repeat (2) step3(0, '0, 1, 0);

    // 6: async reset between edges at count=2.
    step3(1, 16'h0D01, 0, 0);
    step3(1, 16'h0D02, 0, 0);
    v3 = 1'b0;
    #2;
    rst = 1'b1;
    model_cnt = 0;
    exp_q.delete();
    #1;
    check("async_v", {31'b0, vo3}, 32'h0);
    check("async_cnt", {30'b0, cnt3}, 32'h0);
    check("async_ready", {31'b0, rdy_o3}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with protocol-compliant hold of refused entries.
    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        pend = 1'($urandom_range(0, 1));
        pd   = W'($urandom);
      end
      rdy = ((i / 150) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      if (fl || (pend && model_cnt < 3)) begin
        step3(pend, pd, rdy, fl);
        pend = 1'b0;
      end else begin
        step3(pend, pd, rdy, fl);
      end
    end
    repeat (4) step3(0, '0, 1, 0);
    check("final_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
